// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared definitions for the instruction-memory loader.
// Contents: loader FSM state encoding, the HALT instruction word, and helpers
// that derive memory capacity in words and the width of the word counter.
package program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // Memory capacity in instruction words.
  function automatic int calc_words(input int cells, input int inst_bits, input int nbits);
    return cells / (inst_bits / nbits);
  endfunction

  // The counter must be able to hold the value WORDS itself (memory full).
  function automatic int wc_width(input int words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer: assembles NBITS-wide bytes into one INST_BITS-wide word,
// first byte received landing in the most significant position.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          discard any partially assembled word
//   i_byte_vld     i_byte is valid this cycle
//   i_byte         received byte
//   o_word         last completed word, held until the next word completes
//   o_word_vld     one-cycle strobe, the cycle after the final byte arrives
module byte_packer #(
  parameter int NBITS     = 8,
  parameter int INST_BITS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_byte_vld,
  input  logic [NBITS-1:0]     i_byte,
  output logic [INST_BITS-1:0] o_word,
  output logic                 o_word_vld
);

  localparam int BPW   = INST_BITS / NBITS;
  localparam int IDX_W = $clog2(BPW);

  logic [IDX_W-1:0]     idx_p0;
  logic [INST_BITS-1:0] shift_p0;
  logic [INST_BITS-1:0] shift_nxt;
  logic                 last_byte;
  logic [INST_BITS-1:0] word_p1;
  logic                 vld_p1;

  assign shift_nxt = {shift_p0[INST_BITS-NBITS-1:0], i_byte};
  assign last_byte = i_byte_vld && (idx_p0 == IDX_W'(BPW - 1));

  // ---- stage p0: byte index and shift register ----
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      idx_p0 <= '0;
    end else if (i_byte_vld) begin
      idx_p0 <= last_byte ? '0 : idx_p0 + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_byte_vld) begin
      shift_p0 <= shift_nxt;
    end
  end

  // ---- stage p1: completed word and its strobe ----
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= last_byte;
    end
  end

  // The word register resets to zero so the memory data bus is quiet after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_p1 <= '0;
    end else if (last_byte) begin
      word_p1 <= shift_nxt;
    end
  end

  assign o_word     = word_p1;
  assign o_word_vld = vld_p1;

endmodule

// File: rtl/program_loader.sv
// program_loader: loads the big-endian instruction memory from a UART byte
// stream and shares the memory address port with the CPU fetch PC.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               begin a load (honoured in IDLE or DONE)
//   i_rx_data/i_rx_valid  received byte and its one-cycle strobe
//   i_pc                  CPU fetch address, drives memory outside a load
//   o_mem_addr/data/wr_en instruction memory address, write data, write enable
//   o_loading             load in progress, CPU must stall
//   o_done                load finished
//   o_overflow            load ended because memory filled without HALT
//   o_word_count          words written in the current or last load
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int INST_BITS = 32,
  parameter int CELLS     = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NBITS-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  input  logic [INST_BITS-1:0] i_pc,
  output logic [INST_BITS-1:0] o_mem_addr,
  output logic [INST_BITS-1:0] o_mem_data,
  output logic                 o_mem_wr_en,
  output logic                 o_loading,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [wc_width(calc_words(CELLS, INST_BITS, NBITS))-1:0] o_word_count
);

  localparam int WORDS   = calc_words(CELLS, INST_BITS, NBITS);
  localparam int WC_W    = wc_width(WORDS);
  localparam int ADDR_SH = $clog2(INST_BITS / NBITS);

  state_t               state_q;
  state_t               state_nxt;
  logic                 in_load;
  logic                 start_acc;
  logic [INST_BITS-1:0] pk_word;
  logic                 pk_vld;
  logic                 wr_en;
  logic                 is_halt;
  logic                 last_slot;
  logic [WC_W-1:0]      wcnt_q;
  logic                 ovf_q;
  logic [INST_BITS-1:0] wr_addr;

  assign in_load   = (state_q == ST_LOAD);
  assign start_acc = i_start && !in_load;
  assign wr_en     = pk_vld && in_load;
  assign is_halt   = (pk_word == INST_BITS'(HALT_WORD));
  assign last_slot = (wcnt_q == WC_W'(WORDS - 1));
  assign wr_addr   = INST_BITS'(wcnt_q) << ADDR_SH;

  byte_packer #(
    .NBITS    (NBITS),
    .INST_BITS(INST_BITS)
  ) u_packer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (start_acc),
    .i_byte_vld(i_rx_valid && in_load),
    .i_byte    (i_rx_data),
    .o_word    (pk_word),
    .o_word_vld(pk_vld)
  );

  // ---- state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // The terminating write happens while still in LOAD; DONE follows one cycle later.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_LOAD;
      ST_LOAD:          if (wr_en && (is_halt || last_slot)) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // ---- word counter and overflow flag ----
  always_ff @(posedge i_clk) begin
    if (i_rst || start_acc) begin
      wcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else if (wr_en) begin
      wcnt_q <= wcnt_q + 1'b1;
      if (last_slot && !is_halt) ovf_q <= 1'b1;
    end
  end

  // ---- outputs and address mux ----
  always_comb begin
    o_loading    = in_load;
    o_done       = (state_q == ST_DONE);
    o_overflow   = ovf_q;
    o_word_count = wcnt_q;
    o_mem_wr_en  = wr_en;
    o_mem_data   = pk_word;
    o_mem_addr   = in_load ? wr_addr : i_pc;
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int NBITS     = 8;
  localparam int INST_BITS = 32;
  localparam int CELLS     = 256;
  localparam int WORDS     = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr_en;
  logic        loading;
  logic        done;
  logic        overflow;
  logic [6:0]  word_count;

  program_loader #(
    .NBITS    (NBITS),
    .INST_BITS(INST_BITS),
    .CELLS    (CELLS)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_pc        (pc),
    .o_mem_addr  (mem_addr),
    .o_mem_data  (mem_data),
    .o_mem_wr_en (mem_wr_en),
    .o_loading   (loading),
    .o_done      (done),
    .o_overflow  (overflow),
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 loading, 2 done
  int          m_state = 0;
  int          m_cnt   = 0;
  int          m_nb    = 0;
  logic [31:0] m_acc   = '0;
  bit          m_ovf   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    if (m_state == 1) begin
      m_acc = {m_acc[23:0], b};
      m_nb++;
      if (m_nb == 4) begin
        exp_q.push_back('{addr: 32'(m_cnt * 4), data: m_acc, cyc: c + 1});
        m_cnt++;
        m_nb = 0;
        if (m_acc == 32'hFFFF_FFFF) begin
          m_state = 2;
          m_ovf   = 1'b0;
        end else if (m_cnt == WORDS) begin
          m_state = 2;
          m_ovf   = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    rst      = r;
    start    = s;
    rx_valid = v;
    rx_data  = d;
    pc       = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b0, 1'b0, 1'b1, b);
    model_byte(b, cyc);
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      idle($urandom_range(0, gmax));
    end
  endtask

  task automatic send_word_gap(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      idle(gap);
    end
  endtask

  task automatic do_start();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    if (m_state != 1) begin
      m_state = 1;
      m_cnt   = 0;
      m_nb    = 0;
      m_ovf   = 1'b0;
    end
  endtask

  task automatic do_reset(input logic with_byte, input logic [7:0] b);
    drive(1'b1, 1'b0, with_byte, b);
    m_state = 0;
    m_cnt   = 0;
    m_nb    = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_loading"}, 64'(loading), 64'(m_state == 1));
    check({tag, "_done"}, 64'(done), 64'(m_state == 2));
    check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, "_word_count"}, 64'(word_count), 64'(m_cnt));
    if (m_state == 1) check({tag, "_load_addr"}, 64'(mem_addr), 64'(m_cnt * 4));
    else              check({tag, "_pc_addr"}, 64'(mem_addr), 64'(pc));
    check({tag, "_wr_en_quiet"}, 64'(mem_wr_en), 64'(0));
  endtask

  // Monitor: every write strobe must match the next expected write, in the expected cycle.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required no write", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_data), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [12];
    prog = '{8'h3C, 8'h08, 8'h00, 8'h00, 8'h81, 8'h09, 8'h00, 8'h01,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0; pc = 32'h10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_addr", 64'(mem_addr), 64'h10);
    check("rst_wr_en", 64'(mem_wr_en), 64'(0));
    check("rst_data", 64'(mem_data), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_loading", 64'(loading), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));

    // Back-to-back program
    do_start();
    idle(1);
    check_status("start_b2b");
    for (int i = 0; i < 12; i++) send_byte(prog[i]);
    idle(3);
    check_status("b2b");

    // Same program, a byte every third cycle
    do_start();
    for (int i = 0; i < 12; i++) begin
      send_byte(prog[i]);
      idle(2);
    end
    idle(2);
    check_status("gapped");

    // Fill memory without HALT, then extra bytes that must be ignored
    do_start();
    for (int w = 0; w < WORDS; w++) send_word_gap(32'h0000_0001, 0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    idle(3);
    check_status("full");

    // Restart from DONE clears overflow; start during load is ignored
    do_start();
    idle(1);
    check_status("restart");
    send_byte(8'hFF);
    send_byte(8'hFF);
    do_start();
    send_byte(8'hFF);
    send_byte(8'hFF);
    idle(3);
    check_status("halt_only");

    // Reset with a partial word pending
    do_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset(1'b0, 8'h00);
    idle(1);
    check_status("mid_reset");
    do_start();
    send_word_gap(32'hAABB_CCDD, 0);
    idle(3);
    check_status("after_reset");

    // Reset arriving together with the fourth byte
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset(1'b1, 8'h44);
    idle(2);
    check_status("reset_4th");

    // Randomized loads
    for (int it = 0; it < 8; it++) begin
      do_reset(1'b0, 8'h00);
      idle(1);
      do_start();
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) send_word($urandom, 2);
      if ($urandom_range(0, 1) == 1) send_word(32'hFFFF_FFFF, 2);
      idle(3);
      check_status("random");
    end

    idle(2);
    check("pending_writes", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
